register_file_mp: RTL

- Parametrised multi-read-port register file for the pipelined core; next generation of the 2-read/1-write file.
- Generalised data width, depth and read-port count.
- Adds optional hardwired-zero register 0, registered reads with one-cycle latency, and a software-triggered sequential clear engine with busy/done handshake.
- Sits between decode (read addresses) and writeback (write port).

---
 rtl/register_file_mp.sv | 137 +++++++++++++
 1 files changed

// File: rtl/register_file_mp.sv
// Multi-read-port register file: registered reads, optional zero register, sequential clear engine.
// Optional write-first forwarding on read ports is enabled by defining RF_WRITE_BYPASS_EN.

module register_file_mp_rd_lane #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] rd_word,
  input  logic              zero_hit,
  input  logic              clearing,
  input  logic              byp_hit,
  input  logic [DATA_W-1:0] byp_data,
  output logic [DATA_W-1:0] rdata
);
  logic [DATA_W-1:0] rdata_q, rdata_d;

  // Clear and zero-register rules outrank forwarding.
  always_comb begin
    rdata_d = rd_word;
    if (clearing || zero_hit) rdata_d = '0;
    else if (byp_hit)         rdata_d = byp_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) rdata_q <= '0;
    else     rdata_q <= rdata_d;
  end

  assign rdata = rdata_q;
endmodule

module register_file_mp #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int NUM_RD   = 2,
  parameter int ZERO_REG = 1
) (
  input  logic                     CLK_RegFileMP,
  input  logic                     RST_RegFileMP,
  input  logic                     we,
  input  logic [ADDR_W-1:0]        waddr,
  input  logic [DATA_W-1:0]        wdata,
  input  logic [NUM_RD*ADDR_W-1:0] raddr,
  output logic [NUM_RD*DATA_W-1:0] rdata,
  input  logic                     clr_req,
  output logic                     clr_busy,
  output logic                     clr_done
);
  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W:0] LAST_IDX = (ADDR_W+1)'(DEPTH - 1);

  typedef enum logic [1:0] {S_IDLE, S_CLEAR, S_DONE} state_e;

  state_e              state_q, state_d;
  logic [ADDR_W:0]     idx_q, idx_d;
  logic                clr_busy_q, clr_busy_d;
  logic                clr_done_q, clr_done_d;
  logic [DATA_W-1:0]   mem_q [DEPTH];
  logic [DATA_W-1:0]   mem_d [DEPTH];
  logic                clearing, wr_en;
  logic [NUM_RD-1:0][DATA_W-1:0] rdata_lane;

  assign clearing = (state_q == S_CLEAR);
  assign wr_en    = (state_q == S_IDLE) && we && !((ZERO_REG != 0) && (waddr == '0));

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    clr_busy_d = clr_busy_q;
    clr_done_d = 1'b0;
    unique case (state_q)
      S_IDLE: if (clr_req) begin
        state_d    = S_CLEAR;
        idx_d      = '0;
        clr_busy_d = 1'b1;
      end
      S_CLEAR: begin
        idx_d = idx_q + (ADDR_W+1)'(1);
        if (idx_q == LAST_IDX) begin
          state_d    = S_DONE;
          clr_busy_d = 1'b0;
          clr_done_d = 1'b1;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    mem_d = mem_q;
    if (clearing)   mem_d[idx_q[ADDR_W-1:0]] = '0;
    else if (wr_en) mem_d[waddr] = wdata;
  end

  always_ff @(posedge CLK_RegFileMP or posedge RST_RegFileMP) begin
    if (RST_RegFileMP) begin
      state_q    <= S_IDLE;
      idx_q      <= '0;
      clr_busy_q <= 1'b0;
      clr_done_q <= 1'b0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      clr_busy_q <= clr_busy_d;
      clr_done_q <= clr_done_d;
      mem_q      <= mem_d;
    end
  end

  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    logic [ADDR_W-1:0] ra;
    logic              byp_hit;
    assign ra = raddr[k*ADDR_W +: ADDR_W];
`ifdef RF_WRITE_BYPASS_EN
    assign byp_hit = wr_en && (waddr == ra);
`else
    assign byp_hit = 1'b0;
`endif
    register_file_mp_rd_lane #(.DATA_W(DATA_W)) u_lane (
      .clk      (CLK_RegFileMP),
      .rst      (RST_RegFileMP),
      .rd_word  (mem_q[ra]),
      .zero_hit ((ZERO_REG != 0) && (ra == '0)),
      .clearing (clearing),
      .byp_hit  (byp_hit),
      .byp_data (wdata),
      .rdata    (rdata_lane[k])
    );
  end

  assign rdata    = rdata_lane;
  assign clr_busy = clr_busy_q;
  assign clr_done = clr_done_q;
endmodule
